// File: rtl/dds_tuner.sv
// dds_tuner: encoder-tuned DDS channel.
// A quadrature encoder is synchronised and decoded into detent events. Each
// event moves a saturating tuning word by 1 << Step_i. A phase accumulator
// driven by that word feeds a registered square, saw or triangle output.
// Ports:
//   Clock, Reset          - clock; asynchronous active-low reset
//   EncoderA_i/B_i        - raw encoder channels (asynchronous, idle high)
//   Step_i                - step exponent for tuning updates
//   Mode_i                - 0 square, 1 saw, 2 triangle, 3 off
//   Enable_i              - accumulator advance enable
//   PhaseClear_i          - synchronous accumulator clear (wins over Enable_i)
//   TuningWord_o          - current tuning word
//   Changed_o             - one-cycle pulse after the tuning word changes
//   Signal_o              - registered accumulator MSB (0 in mode 3)
//   Wave_o                - registered waveform sample
module dds_tuner #(
    parameter int unsigned          ACC_WIDTH = 32,
    parameter int unsigned          TW_WIDTH  = 24,
    parameter int unsigned          OUT_WIDTH = 8,
    parameter logic [TW_WIDTH-1:0]  TW_RESET  = '0,
    parameter logic [TW_WIDTH-1:0]  TW_MIN    = '0,
    parameter logic [TW_WIDTH-1:0]  TW_MAX    = {TW_WIDTH{1'b1}},
    parameter int unsigned          STEP_BITS = 3
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 EncoderA_i,
    input  logic                 EncoderB_i,
    input  logic [STEP_BITS-1:0] Step_i,
    input  logic [1:0]           Mode_i,
    input  logic                 Enable_i,
    input  logic                 PhaseClear_i,
    output logic [TW_WIDTH-1:0]  TuningWord_o,
    output logic                 Changed_o,
    output logic                 Signal_o,
    output logic [OUT_WIDTH-1:0] Wave_o
);

    localparam int unsigned SUM_W = TW_WIDTH + 1;

    // Encoder synchronisers and decoder state
    logic              a_meta_q, a_sync_q, b_meta_q, b_sync_q;
    logic [1:0]        ab_c;
    logic [1:0]        prev_q;
    logic signed [2:0] cnt_q, cnt_d;
    logic              inc_q, inc_d, dec_q, dec_d;

    // Tuning word
    logic [TW_WIDTH-1:0] tw_q, tw_d;
    logic                changed_q, changed_d;
    logic [SUM_W-1:0]    step_c, sum_c, diff_c;

    // Phase accumulator and output stage
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [OUT_WIDTH:0]   p_c;
    logic                 msb_c;
    logic                 signal_q, signal_d;
    logic [OUT_WIDTH-1:0] wave_q, wave_d;

    assign ab_c = {a_sync_q, b_sync_q};

    // Two-flop synchronisers; idle level is high
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            a_meta_q <= 1'b1;
            a_sync_q <= 1'b1;
            b_meta_q <= 1'b1;
            b_sync_q <= 1'b1;
        end else begin
            a_meta_q <= EncoderA_i;
            a_sync_q <= a_meta_q;
            b_meta_q <= EncoderB_i;
            b_sync_q <= b_meta_q;
        end
    end

    // Quadrature decode: count quarter steps, fire on a full detent into 11.
    // Every arrival at 11 clears the count, so bounces never accumulate.
    always_comb begin
        cnt_d = cnt_q;
        inc_d = 1'b0;
        dec_d = 1'b0;
        if (ab_c != prev_q) begin
            case ({prev_q, ab_c})
                4'b11_01, 4'b01_00, 4'b00_10, 4'b10_11: cnt_d = cnt_q + 3'sd1;
                4'b11_10, 4'b10_00, 4'b00_01, 4'b01_11: cnt_d = cnt_q - 3'sd1;
                default:                                cnt_d = cnt_q;
            endcase
            if (ab_c == 2'b11) begin
                inc_d = (prev_q == 2'b10) && (cnt_q == 3'sd3);
                dec_d = (prev_q == 2'b01) && (cnt_q == -3'sd3);
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            prev_q <= 2'b11;
            cnt_q  <= '0;
            inc_q  <= 1'b0;
            dec_q  <= 1'b0;
        end else begin
            prev_q <= ab_c;
            cnt_q  <= cnt_d;
            inc_q  <= inc_d;
            dec_q  <= dec_d;
        end
    end

    // Saturating tuning word update; one extra bit catches overflow/borrow
    always_comb begin
        step_c    = SUM_W'(1) << Step_i;
        sum_c     = {1'b0, tw_q} + step_c;
        diff_c    = {1'b0, tw_q} - step_c;
        tw_d      = tw_q;
        if (inc_q) begin
            tw_d = (sum_c > {1'b0, TW_MAX}) ? TW_MAX : sum_c[TW_WIDTH-1:0];
        end else if (dec_q) begin
            tw_d = (diff_c[TW_WIDTH] || (diff_c[TW_WIDTH-1:0] < TW_MIN))
                   ? TW_MIN : diff_c[TW_WIDTH-1:0];
        end
        changed_d = (tw_d != tw_q);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            tw_q      <= TW_RESET;
            changed_q <= 1'b0;
        end else begin
            tw_q      <= tw_d;
            changed_q <= changed_d;
        end
    end

    // Phase accumulator; clear has priority, wraps silently
    always_comb begin
        acc_d = acc_q;
        if (PhaseClear_i) begin
            acc_d = '0;
        end else if (Enable_i) begin
            acc_d = acc_q + ACC_WIDTH'(tw_q);
        end
    end

    // Waveform shaping from the top OUT_WIDTH+1 accumulator bits
    always_comb begin
        p_c      = acc_q[ACC_WIDTH-1 -: OUT_WIDTH+1];
        msb_c    = p_c[OUT_WIDTH];
        signal_d = (Mode_i != 2'd3) && msb_c;
        wave_d   = '0;
        case (Mode_i)
            2'd0:    wave_d = {OUT_WIDTH{msb_c}};
            2'd1:    wave_d = p_c[OUT_WIDTH:1];
            2'd2:    wave_d = msb_c ? ~p_c[OUT_WIDTH-1:0] : p_c[OUT_WIDTH-1:0];
            default: wave_d = '0;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            acc_q    <= '0;
            signal_q <= 1'b0;
            wave_q   <= '0;
        end else begin
            acc_q    <= acc_d;
            signal_q <= signal_d;
            wave_q   <= wave_d;
        end
    end

    assign TuningWord_o = tw_q;
    assign Changed_o    = changed_q;
    assign Signal_o     = signal_q;
    assign Wave_o       = wave_q;

endmodule

// File: tb/tb_dds_tuner.sv
// tb_dds_tuner: directed + randomized bench for dds_tuner.
// dut0 uses default bounds (encoder/tuning checks); dut1 pins the tuning word
// at 2^23 (TW_RESET = TW_MAX) for waveform checks against an arithmetic model.
module tb_dds_tuner;

    localparam int HOLD = 4;
    localparam longint TWW   = 64'h80_0000;
    localparam longint MAX0  = 64'hFF_FFFF;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic a0, b0, a1, b1;
    logic [2:0] step0, step1;
    logic [1:0] mode0, mode1;
    logic en0, en1, clr0, clr1;
    logic [23:0] tw0, tw1;
    logic chg0, chg1, sig0, sig1;
    logic [7:0] wave0, wave1;

    dds_tuner dut0 (
        .Clock(clk), .Reset(rst_n), .EncoderA_i(a0), .EncoderB_i(b0),
        .Step_i(step0), .Mode_i(mode0), .Enable_i(en0), .PhaseClear_i(clr0),
        .TuningWord_o(tw0), .Changed_o(chg0), .Signal_o(sig0), .Wave_o(wave0)
    );

    dds_tuner #(
        .TW_RESET(24'h80_0000), .TW_MAX(24'h80_0000)
    ) dut1 (
        .Clock(clk), .Reset(rst_n), .EncoderA_i(a1), .EncoderB_i(b1),
        .Step_i(step1), .Mode_i(mode1), .Enable_i(en1), .PhaseClear_i(clr1),
        .TuningWord_o(tw1), .Changed_o(chg1), .Signal_o(sig1), .Wave_o(wave1)
    );

    int errs = 0;
    int checks = 0;
    longint tw_ref0 = 0;
    longint tw_ref1 = TWW;
    int chg_cnt0 = 0;

    always @(negedge clk) if (chg0 === 1'b1) chg_cnt0++;

    // Reference model for dut1: phase as an integer, samples from phase fraction
    longint unsigned acc_m;
    longint unsigned p_m;
    bit msb_m;
    logic [7:0] exp_wave;
    logic exp_sig;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_m = 0; exp_wave = 8'd0; exp_sig = 1'b0;
        end else begin
            msb_m = (acc_m >= 64'h8000_0000);
            p_m   = acc_m >> 23;
            case (mode1)
                2'd0:    exp_wave = msb_m ? 8'd255 : 8'd0;
                2'd1:    exp_wave = 8'(acc_m >> 24);
                2'd2:    exp_wave = (p_m < 256) ? 8'(p_m) : 8'(511 - p_m);
                default: exp_wave = 8'd0;
            endcase
            exp_sig = (mode1 != 2'd3) && msb_m;
            if (clr1) acc_m = 0;
            else if (en1) acc_m = (acc_m + TWW) % (64'd1 << 32);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_ab(input bit sel, input logic [1:0] ab);
        if (sel) {a1, b1} = ab; else {a0, b0} = ab;
    endtask

    task automatic tick_w(input string tag);
        @(posedge clk); #1;
        check({tag, "_wave"}, wave1, exp_wave);
        check({tag, "_sig"}, sig1, exp_sig);
    endtask

    // One full detent; checks latency, new value and the Changed_o pulse
    task automatic detent(input bit sel, input bit fwd, input logic [2:0] st);
        logic [1:0] seq [4];
        longint o, n, s, mx;
        o  = sel ? tw_ref1 : tw_ref0;
        mx = sel ? TWW : MAX0;
        s  = longint'(1) << st;
        if (fwd) n = (o + s > mx) ? mx : o + s;
        else     n = (s > o) ? 0 : o - s;
        if (sel) step1 = st; else step0 = st;
        if (fwd) seq = '{2'b01, 2'b00, 2'b10, 2'b11};
        else     seq = '{2'b10, 2'b00, 2'b01, 2'b11};
        for (int i = 0; i < 3; i++) begin
            set_ab(sel, seq[i]);
            cyc(HOLD);
        end
        set_ab(sel, seq[3]);
        cyc(3);
        check("tw_before_latency", sel ? tw1 : tw0, o);
        cyc(1);
        check("tw_after_detent", sel ? tw1 : tw0, n);
        check("changed_pulse", sel ? chg1 : chg0, (n != o) ? 1 : 0);
        cyc(1);
        check("changed_one_cycle", sel ? chg1 : chg0, 0);
        if (sel) tw_ref1 = n; else tw_ref0 = n;
    endtask

    initial begin
        int c0, hi, tr;
        logic last;
        rst_n = 1'b0;
        a0 = 1; b0 = 1; a1 = 1; b1 = 1;
        step0 = 0; step1 = 0; mode0 = 0; mode1 = 0;
        en0 = 0; en1 = 0; clr0 = 0; clr1 = 0;
        #12;
        check("rst_tw0", tw0, 0);
        check("rst_tw1", tw1, TWW);
        check("rst_chg0", chg0, 0);
        check("rst_sig1", sig1, 0);
        check("rst_wave1", wave1, 0);
        #3 rst_n = 1'b1;
        cyc(3);

        // Ten forward detents at step 1
        c0 = chg_cnt0;
        for (int i = 0; i < 10; i++) detent(0, 1, 3'd0);
        check("fwd10_tw", tw0, 10);
        check("fwd10_pulses", chg_cnt0 - c0, 10);

        // Reverse at step 4 down to and beyond the lower bound
        c0 = chg_cnt0;
        for (int i = 0; i < 4; i++) detent(0, 0, 3'd2);
        check("rev_clamp_tw", tw0, 0);
        check("rev_clamp_pulses", chg_cnt0 - c0, 3);

        // Half rotation then a one-cycle 11->00 glitch: no event
        c0 = chg_cnt0;
        set_ab(0, 2'b01); cyc(HOLD);
        set_ab(0, 2'b00); cyc(HOLD);
        set_ab(0, 2'b01); cyc(HOLD);
        set_ab(0, 2'b11); cyc(HOLD);
        set_ab(0, 2'b00); cyc(1);
        set_ab(0, 2'b11); cyc(8);
        check("glitch_tw", tw0, tw_ref0);
        check("glitch_pulses", chg_cnt0 - c0, 0);

        // Random detents with occasional aborted quarter-steps
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                set_ab(0, 2'b01); cyc(HOLD);
                set_ab(0, 2'b11); cyc(HOLD);
            end
            detent(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end

        // Square wave: 50% duty, period 512
        en1 = 1; mode1 = 2'd0;
        cyc(1);
        hi = 0; tr = 0; last = sig1;
        for (int i = 0; i < 512; i++) begin
            tick_w("square");
            if (sig1 === 1'b1) hi++;
            if (sig1 !== last) tr++;
            last = sig1;
        end
        check("square_duty", hi, 256);
        check("square_edges", tr, 2);

        // Triangle, with a brief detour through mode 3
        mode1 = 2'd2;
        for (int i = 0; i < 600; i++) begin
            if (i == 200) mode1 = 2'd3;
            if (i == 205) mode1 = 2'd2;
            tick_w("triangle");
            if (i == 200) check("off_wave", wave1, 0);
        end

        // Random mode / enable / clear
        for (int i = 0; i < 300; i++) begin
            mode1 = 2'($urandom_range(0, 3));
            en1   = ($urandom_range(0, 3) != 0);
            clr1  = ($urandom_range(0, 31) == 0);
            tick_w("random");
        end
        clr1 = 0; en1 = 1; mode1 = 2'd2;
        check("dut0_wave_idle", wave0, 0);
        check("dut0_sig_idle", sig0, 0);

        // Reset mid-detent and mid-ramp
        for (int i = 0; i < 40; i++) tick_w("pre_reset");
        set_ab(0, 2'b01); cyc(HOLD);
        set_ab(0, 2'b00); cyc(HOLD);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_tw0", tw0, 0);
        check("async_rst_tw1", tw1, TWW);
        check("async_rst_chg0", chg0, 0);
        check("async_rst_sig1", sig1, 0);
        check("async_rst_wave1", wave1, 0);
        tw_ref0 = 0; tw_ref1 = TWW;
        @(posedge clk); @(posedge clk); #4;
        rst_n = 1'b1;
        cyc(1);
        for (int i = 0; i < 20; i++) tick_w("post_reset");
        set_ab(0, 2'b10); cyc(HOLD);
        set_ab(0, 2'b11); cyc(8);
        check("partial_after_reset", tw0, 0);
        detent(0, 1, 3'd0);
        check("detent_after_reset", tw0, 1);

        // Upper bound on dut1 with the accumulator stopped
        en1 = 0;
        detent(1, 1, 3'd3);
        detent(1, 0, 3'd3);
        detent(1, 1, 3'd4);
        check("upper_clamp_tw1", tw1, TWW);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
